mdz_triplet_sched: RTL

Controller that shares one external triplet-merge datapath between two requesters. Each requester offers a 96-bit triplet over valid/ready; the scheduler grants, latches the operands, drives the datapath's merge/which/operand inputs, waits the datapath latency, and returns the 32-bit result with equal flag over a valid/ready output port. When merging is enabled and both requesters are valid, their triplets are combined in one datapath pass. Otherwise single requests are passed through, arbitrated round-robin.

---
 rtl/mdz_sched_pkg.sv | 21 ++
 rtl/mdz_triplet_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mdz_sched_pkg.sv
// Shared types and source codes for the triplet-merge scheduler.
package mdz_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] b;
    logic [31:0] a;
  } triplet_t;

  localparam logic [1:0] SRC_R0  = 2'b01;
  localparam logic [1:0] SRC_R1  = 2'b10;
  localparam logic [1:0] SRC_MRG = 2'b11;

endpackage

// File: rtl/mdz_triplet_sched.sv
// Shares one triplet-merge datapath between two requesters: grants, latches
// operands, waits out the datapath latency and returns the result.
module mdz_triplet_sched
  import mdz_sched_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             merge_en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [95:0]      req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [95:0]      req1_data,
  output logic             dp_merge,
  output logic             dp_which,
  output logic [31:0]      dp_ai,
  output logic [31:0]      dp_bi,
  output logic [31:0]      dp_ci,
  output logic [31:0]      dp_di,
  output logic [31:0]      dp_ei,
  output logic [31:0]      dp_fi,
  input  logic [31:0]      dp_q,
  input  logic             dp_equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_equal,
  output logic [1:0]       out_src,
  output logic             busy,
  output logic [CNT_W-1:0] merge_count
);

  if (LATENCY != 0 && LATENCY != 1) begin : g_bad_latency
    $fatal(1, "mdz_triplet_sched: LATENCY must be 0 or 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t   state, state_n;
  logic     rr_ptr;
  triplet_t slot_a, slot_b;
  logic     grant0, grant1;
  logic     granted, merged, capture;

  // Grant decision is combinational so a requester sees ready in the same
  // cycle it raises valid; rr_ptr = 1 favours requester 1.
  always_comb begin
    state_n = state;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          if (merge_en) begin
            grant0 = 1'b1;
            grant1 = 1'b1;
          end else if (rr_ptr) begin
            grant1 = 1'b1;
          end else begin
            grant0 = 1'b1;
          end
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        if (grant0 || grant1) state_n = ST_EXEC;
      end
      ST_EXEC: state_n = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: state_n = ST_RESP;
      ST_RESP: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign granted    = grant0 || grant1;
  assign merged     = grant0 && grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign capture    = ((state == ST_EXEC) && (LATENCY == 0)) || (state == ST_WAIT);

  assign out_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  assign dp_ai = slot_a.a;
  assign dp_bi = slot_a.b;
  assign dp_ci = slot_a.c;
  assign dp_di = slot_b.a;
  assign dp_ei = slot_b.b;
  assign dp_fi = slot_b.c;

  // A single grant points the arbiter at the other side; a merge leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_n;
      if (granted && !merged) rr_ptr <= grant0;
    end
  end

  // Ungranted slot keeps its old operands; datapath controls change only at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_a   <= '0;
      slot_b   <= '0;
      dp_merge <= 1'b0;
      dp_which <= 1'b0;
      out_src  <= 2'b00;
    end else begin
      if (grant0) slot_a <= req0_data;
      if (grant1) slot_b <= req1_data;
      if (granted) begin
        dp_merge <= merged;
        dp_which <= grant1 && !grant0;
        out_src  <= merged ? SRC_MRG : (grant1 ? SRC_R1 : SRC_R0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_equal <= 1'b0;
    end else if (capture) begin
      out_data  <= dp_q;
      out_equal <= dp_equal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_count <= '0;
    end else if (merged && (merge_count != CNT_MAX)) begin
      merge_count <= merge_count + CNT_ONE;
    end
  end

endmodule
